ship_registry: RTL and testbench

//  Parametrised ship register file for the battleship game: holds placement (origin, length,

---
 rtl/ship_registry.sv | 229 ++++++++++++++++++++++
 tb/tb_ship_registry.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ship_registry.sv
// Battleship ship register file: placement + per-segment hit masks, sequential shot-resolving scan.
// Optional board bounds check on writes when SHIP_REG_BOUNDS_CHECK_EN is defined (adds BOARD_SIZE).
module ship_registry #(
    parameter int NUM_SHIPS = 5,
    parameter int COORD_W   = 4,
    parameter int MAX_LEN   = 5,
`ifdef SHIP_REG_BOUNDS_CHECK_EN
    parameter int BOARD_SIZE = 10,
`endif
    localparam int IDX_W = (NUM_SHIPS > 1) ? $clog2(NUM_SHIPS) : 1,
    localparam int LEN_W = $clog2(MAX_LEN + 1),
    localparam int CNT_W = $clog2(NUM_SHIPS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [COORD_W-1:0] wr_row,
    input  logic [COORD_W-1:0] wr_col,
    input  logic [LEN_W-1:0]   wr_len,
    input  logic               wr_vert,
    output logic               wr_err,
    input  logic               shot_valid,
    output logic               shot_ready,
    input  logic [COORD_W-1:0] shot_row,
    input  logic [COORD_W-1:0] shot_col,
    output logic               result_valid,
    output logic               result_hit,
    output logic               result_sunk,
    output logic               result_repeat,
    output logic [IDX_W-1:0]   result_idx,
    output logic [CNT_W-1:0]   ships_alive,
    output logic               all_sunk,
    output logic [1:0]         dbg_state
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SCAN   = 2'd1;
    localparam logic [1:0] S_REPORT = 2'd2;
    localparam int CMP_W = (COORD_W > LEN_W) ? COORD_W : LEN_W;

    function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] len);
        logic [MAX_LEN-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            m[i] = (32'(i) < 32'(len));
        end
        return m;
    endfunction

    function automatic logic is_sunk(input logic [MAX_LEN-1:0] mask, input logic [LEN_W-1:0] len);
        return (len != '0) && (&(mask | ~len_mask(len)));
    endfunction

    logic [COORD_W-1:0] r_row  [NUM_SHIPS];
    logic [COORD_W-1:0] r_col  [NUM_SHIPS];
    logic [LEN_W-1:0]   r_len  [NUM_SHIPS];
    logic               r_vert [NUM_SHIPS];
    logic [MAX_LEN-1:0] r_mask [NUM_SHIPS];

    logic [1:0]         r_state;
    logic [IDX_W-1:0]   r_scan_idx;
    logic [COORD_W-1:0] r_shot_row;
    logic [COORD_W-1:0] r_shot_col;
    logic               r_res_hit;
    logic               r_res_sunk;
    logic               r_res_rep;
    logic [IDX_W-1:0]   r_res_idx;
    logic               r_wr_err;
    logic [CNT_W-1:0]   r_alive;
    logic               r_all_sunk;

    logic               w_idle;
    logic [COORD_W-1:0] w_cur_row;
    logic [COORD_W-1:0] w_cur_col;
    logic [LEN_W-1:0]   w_cur_len;
    logic               w_cur_vert;
    logic [MAX_LEN-1:0] w_cur_mask;
    logic [COORD_W-1:0] w_off;
    logic               w_axis_ok;
    logic               w_match;
    logic [MAX_LEN-1:0] w_bit;
    logic [MAX_LEN-1:0] w_new_mask;
    logic               w_repeat;
    logic               w_sunk;
    logic               w_last;
    logic [CNT_W-1:0]   w_alive;
    logic               w_any_active;
    logic               w_len_ok;
    logic               w_idx_ok;
    logic               w_bounds_ok;
    logic               w_wr_accept;
    logic               w_wr_reject;
    logic               w_shot_accept;

    assign w_idle = (r_state == S_IDLE);

    // Shot handshake: a shot transfers on a cycle with shot_valid && shot_ready. shot_ready is high
    // only when idle and no write or clear is presented that cycle, so writes always win over shots.
    assign shot_ready    = w_idle && !wr_en && !clear;
    assign w_shot_accept = shot_valid && shot_ready;

    assign w_cur_row  = r_row[r_scan_idx];
    assign w_cur_col  = r_col[r_scan_idx];
    assign w_cur_len  = r_len[r_scan_idx];
    assign w_cur_vert = r_vert[r_scan_idx];
    assign w_cur_mask = r_mask[r_scan_idx];

    // Offset along the ship axis wraps modulo the coordinate width, so ships may wrap off-board.
    assign w_off      = w_cur_vert ? (r_shot_row - w_cur_row) : (r_shot_col - w_cur_col);
    assign w_axis_ok  = w_cur_vert ? (r_shot_col == w_cur_col) : (r_shot_row == w_cur_row);
    assign w_match    = w_axis_ok && (w_cur_len != '0) && (CMP_W'(w_off) < CMP_W'(w_cur_len));
    assign w_bit      = MAX_LEN'(1) << w_off;
    assign w_new_mask = w_cur_mask | w_bit;
    assign w_repeat   = |(w_cur_mask & w_bit);
    assign w_sunk     = is_sunk(w_new_mask, w_cur_len);
    assign w_last     = (r_scan_idx == IDX_W'(NUM_SHIPS - 1));

    always_comb begin
        w_alive      = '0;
        w_any_active = 1'b0;
        for (int k = 0; k < NUM_SHIPS; k++) begin
            if (r_len[k] != '0) begin
                w_any_active = 1'b1;
                if (!is_sunk(r_mask[k], r_len[k])) begin
                    w_alive = w_alive + CNT_W'(1);
                end
            end
        end
    end

    assign w_len_ok = (32'(wr_len) <= 32'(MAX_LEN));
    assign w_idx_ok = (32'(wr_idx) < 32'(NUM_SHIPS));

`ifdef SHIP_REG_BOUNDS_CHECK_EN
    logic [COORD_W-1:0] w_axis_origin;
    assign w_axis_origin = wr_vert ? wr_row : wr_col;
    assign w_bounds_ok = (32'(wr_row) < 32'(BOARD_SIZE)) && (32'(wr_col) < 32'(BOARD_SIZE)) &&
                         ((wr_len == '0) ||
                          (32'(w_axis_origin) + 32'(wr_len) - 32'd1 < 32'(BOARD_SIZE)));
`else
    assign w_bounds_ok = 1'b1;
`endif

    assign w_wr_accept = wr_en && w_idle && w_len_ok && w_idx_ok && w_bounds_ok;
    assign w_wr_reject = wr_en && !w_wr_accept;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int k = 0; k < NUM_SHIPS; k++) begin
                r_row[k]  <= '0;
                r_col[k]  <= '0;
                r_len[k]  <= '0;
                r_vert[k] <= 1'b0;
                r_mask[k] <= '0;
            end
        end else if (w_wr_accept) begin
            r_row[wr_idx]  <= wr_row;
            r_col[wr_idx]  <= wr_col;
            r_len[wr_idx]  <= wr_len;
            r_vert[wr_idx] <= wr_vert;
            r_mask[wr_idx] <= '0;
        end else if ((r_state == S_SCAN) && w_match) begin
            r_mask[r_scan_idx] <= w_new_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_state    <= S_IDLE;
            r_scan_idx <= '0;
            r_shot_row <= '0;
            r_shot_col <= '0;
            r_res_hit  <= 1'b0;
            r_res_sunk <= 1'b0;
            r_res_rep  <= 1'b0;
            r_res_idx  <= '0;
            r_wr_err   <= 1'b0;
            r_alive    <= '0;
            r_all_sunk <= 1'b0;
        end else begin
            r_wr_err   <= w_wr_reject;
            r_alive    <= w_alive;
            r_all_sunk <= w_any_active && (w_alive == '0);
            case (r_state)
                S_IDLE: begin
                    if (w_shot_accept) begin
                        r_shot_row <= shot_row;
                        r_shot_col <= shot_col;
                        r_scan_idx <= '0;
                        r_state    <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    // Lowest-index match wins: the scan stops at the first ship covering the cell.
                    if (w_match) begin
                        r_res_hit  <= 1'b1;
                        r_res_sunk <= w_sunk;
                        r_res_rep  <= w_repeat;
                        r_res_idx  <= r_scan_idx;
                        r_state    <= S_REPORT;
                    end else if (w_last) begin
                        r_res_hit  <= 1'b0;
                        r_res_sunk <= 1'b0;
                        r_res_rep  <= 1'b0;
                        r_res_idx  <= '0;
                        r_state    <= S_REPORT;
                    end else begin
                        r_scan_idx <= r_scan_idx + IDX_W'(1);
                    end
                end
                S_REPORT: r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    assign result_valid  = (r_state == S_REPORT);
    assign result_hit    = result_valid && r_res_hit;
    assign result_sunk   = result_valid && r_res_sunk;
    assign result_repeat = result_valid && r_res_rep;
    assign result_idx    = result_valid ? r_res_idx : '0;
    assign wr_err        = r_wr_err;
    assign ships_alive   = r_alive;
    assign all_sunk      = r_all_sunk;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_ship_registry.sv
// Bench for ship_registry: cell-enumerating fleet model checked every cycle, plus directed literals.
module tb_ship_registry;

    localparam int N  = 5;
    localparam int CW = 4;
    localparam int ML = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic          wr_en;
    logic [2:0]    wr_idx;
    logic [CW-1:0] wr_row;
    logic [CW-1:0] wr_col;
    logic [2:0]    wr_len;
    logic          wr_vert;
    logic          wr_err;
    logic          shot_valid;
    logic          shot_ready;
    logic [CW-1:0] shot_row;
    logic [CW-1:0] shot_col;
    logic          result_valid;
    logic          result_hit;
    logic          result_sunk;
    logic          result_repeat;
    logic [2:0]    result_idx;
    logic [2:0]    ships_alive;
    logic          all_sunk;
    logic [1:0]    dbg_state;

    ship_registry #(.NUM_SHIPS(N), .COORD_W(CW), .MAX_LEN(ML)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_row(wr_row), .wr_col(wr_col),
        .wr_len(wr_len), .wr_vert(wr_vert), .wr_err(wr_err),
        .shot_valid(shot_valid), .shot_ready(shot_ready),
        .shot_row(shot_row), .shot_col(shot_col),
        .result_valid(result_valid), .result_hit(result_hit), .result_sunk(result_sunk),
        .result_repeat(result_repeat), .result_idx(result_idx),
        .ships_alive(ships_alive), .all_sunk(all_sunk), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- fleet model ----------------
    int m_row [N];
    int m_col [N];
    int m_len [N];
    bit m_vert [N];
    bit m_hit [N][ML];

    int exp_alive   = 0;
    bit exp_all     = 1'b0;
    int alive_from  = 0;
    int exp_err_cyc = -1;
    int busy_from   = -1;
    int busy_to     = -1;
    int exp_rep_cyc = -1;
    bit res_pending = 1'b0;
    bit e_hit, e_sunk, e_rep;
    int e_idx;
    int t_acc;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_refresh_alive(input int from);
        bit active;
        bit sunk;
        exp_alive = 0;
        active    = 1'b0;
        for (int s = 0; s < N; s++) begin
            if (m_len[s] > 0) begin
                active = 1'b1;
                sunk   = 1'b1;
                for (int i = 0; i < m_len[s]; i++) if (!m_hit[s][i]) sunk = 1'b0;
                if (!sunk) exp_alive++;
            end
        end
        exp_all    = active && (exp_alive == 0);
        alive_from = from;
    endfunction

    function automatic void model_clear_all();
        for (int s = 0; s < N; s++) begin
            m_row[s] = 0; m_col[s] = 0; m_len[s] = 0; m_vert[s] = 1'b0;
            for (int i = 0; i < ML; i++) m_hit[s][i] = 1'b0;
        end
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            bit busy;
            bit exp_rv;
            busy = (cyc >= busy_from) && (cyc <= busy_to);
            check("shot_ready", int'(shot_ready), int'(!busy && !wr_en && !clear));
            exp_rv = res_pending && (cyc == exp_rep_cyc);
            check("result_valid", int'(result_valid), int'(exp_rv));
            if (exp_rv) begin
                check("model_hit", int'(result_hit), int'(e_hit));
                check("model_sunk", int'(result_sunk), int'(e_sunk));
                check("model_repeat", int'(result_repeat), int'(e_rep));
                check("model_idx", int'(result_idx), e_idx);
                res_pending = 1'b0;
            end
            check("wr_err", int'(wr_err), int'(cyc == exp_err_cyc));
            if (cyc >= alive_from) begin
                check("ships_alive", int'(ships_alive), exp_alive);
                check("all_sunk", int'(all_sunk), int'(exp_all));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_shot(input int r, input int c);
        int found;
        int seg;
        int lat;
        int rr;
        int cc;
        found = -1;
        seg   = 0;
        for (int s = 0; s < N && found < 0; s++) begin
            for (int i = 0; i < m_len[s]; i++) begin
                rr = m_vert[s] ? (m_row[s] + i) % 16 : m_row[s];
                cc = m_vert[s] ? m_col[s] : (m_col[s] + i) % 16;
                if (found < 0 && rr == r && cc == c) begin
                    found = s;
                    seg   = i;
                end
            end
        end
        t_acc = cyc;
        if (found >= 0) begin
            e_hit = 1'b1;
            e_idx = found;
            e_rep = m_hit[found][seg];
            m_hit[found][seg] = 1'b1;
            e_sunk = 1'b1;
            for (int i = 0; i < m_len[found]; i++) if (!m_hit[found][i]) e_sunk = 1'b0;
            lat = 2 + found;
            if (!e_rep) model_refresh_alive(t_acc + lat + 1);
        end else begin
            e_hit = 1'b0; e_idx = 0; e_rep = 1'b0; e_sunk = 1'b0;
            lat = 1 + N;
        end
        exp_rep_cyc = t_acc + lat;
        res_pending = 1'b1;
        busy_from   = t_acc + 1;
        busy_to     = t_acc + lat;
        shot_row    = CW'(r);
        shot_col    = CW'(c);
        shot_valid  = 1'b1;
        tick();
        shot_valid  = 1'b0;
    endtask

    task automatic wait_result(input int l_hit, input int l_idx, input int l_sunk,
                               input int l_rep, input int l_lat);
        int n;
        n = 0;
        while (!result_valid && n < 20) begin
            tick();
            n++;
        end
        if (!result_valid) begin
            check("result_timeout", 0, 1);
        end else begin
            check("lit_latency", cyc - t_acc, l_lat);
            check("lit_hit", int'(result_hit), l_hit);
            check("lit_idx", int'(result_idx), l_idx);
            check("lit_sunk", int'(result_sunk), l_sunk);
            check("lit_repeat", int'(result_repeat), l_rep);
        end
        tick();
    endtask

    task automatic write_slot(input int idx, input int r, input int c, input int len,
                              input bit vert, input int l_err);
        int  w;
        bit  busy;
        w    = cyc;
        busy = (w >= busy_from) && (w <= busy_to);
        if (!busy && len <= ML) begin
            m_row[idx] = r; m_col[idx] = c; m_len[idx] = len; m_vert[idx] = vert;
            for (int i = 0; i < ML; i++) m_hit[idx][i] = 1'b0;
            model_refresh_alive(w + 2);
        end else begin
            exp_err_cyc = w + 1;
        end
        wr_idx  = 3'(idx);
        wr_row  = CW'(r);
        wr_col  = CW'(c);
        wr_len  = 3'(len);
        wr_vert = vert;
        wr_en   = 1'b1;
        tick();
        check("lit_wr_err", int'(wr_err), l_err);
        wr_en = 1'b0;
    endtask

    task automatic do_clear();
        int c;
        c = cyc;
        res_pending = 1'b0;
        if (busy_to >= c) busy_to = c;
        model_clear_all();
        exp_alive  = 0;
        exp_all    = 1'b0;
        alive_from = c + 1;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        #1;
        check("lit_clear_ready", int'(shot_ready), 1);
        check("lit_clear_alive", int'(ships_alive), 0);
        check("lit_clear_all_sunk", int'(all_sunk), 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; clear = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_row = '0; wr_col = '0;
        wr_len = '0; wr_vert = 1'b0; shot_valid = 1'b0; shot_row = '0; shot_col = '0;
        model_clear_all();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;

        // 1: reset state and a miss on an empty fleet
        check("lit_reset_ready", int'(shot_ready), 1);
        check("lit_reset_alive", int'(ships_alive), 0);
        check("lit_reset_all_sunk", int'(all_sunk), 0);
        check("lit_reset_valid", int'(result_valid), 0);
        check("lit_reset_wr_err", int'(wr_err), 0);
        start_shot(3, 3);
        wait_result(0, 0, 0, 0, 6);

        // 2: horizontal ship in slot 1, first hit
        write_slot(1, 2, 2, 3, 1'b0, 0);
        tick();
        check("lit_alive_one", int'(ships_alive), 1);
        start_shot(2, 3);
        wait_result(1, 1, 0, 0, 3);

        // 3: finish the ship off
        start_shot(2, 2);
        wait_result(1, 1, 0, 0, 3);
        start_shot(2, 4);
        wait_result(1, 1, 1, 0, 3);
        tick();
        check("lit_alive_zero", int'(ships_alive), 0);
        check("lit_all_sunk", int'(all_sunk), 1);

        // 4: repeat hit on a sunk ship
        start_shot(2, 3);
        wait_result(1, 1, 1, 1, 3);

        // 5: oversize write rejected, slot contents preserved
        write_slot(3, 5, 1, 2, 1'b1, 0);
        write_slot(3, 0, 0, 6, 1'b0, 1);
        tick();
        start_shot(6, 1);
        wait_result(1, 3, 0, 0, 5);

        // 5b: write during scan rejected, scan unaffected
        start_shot(0, 0);
        write_slot(0, 0, 0, 1, 1'b0, 1);
        wait_result(0, 0, 0, 0, 6);
        start_shot(0, 0);
        wait_result(0, 0, 0, 0, 6);

        // 5c: write and shot in the same idle cycle: write wins, shot dropped
        shot_row = 4'd8; shot_col = 4'd8; shot_valid = 1'b1;
        write_slot(4, 8, 8, 1, 1'b0, 0);
        shot_valid = 1'b0;
        repeat (3) tick();
        start_shot(8, 8);
        wait_result(1, 4, 1, 0, 6);

        // horizontal ship wrapping past column 15 into column 0
        write_slot(0, 2, 14, 3, 1'b0, 0);
        tick();
        start_shot(2, 0);
        wait_result(1, 0, 0, 0, 2);
        tick();
        check("lit_alive_two", int'(ships_alive), 2);

        // 6: clear while scanning
        start_shot(9, 9);
        tick();
        do_clear();
        repeat (8) tick();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
